// File: rtl/id_operand_unit.sv
// id_operand_unit: IF->ID pipeline register, register file with write-through,
// priority-ordered operand forwarding and load-use stall request generation.
module id_operand_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_if,
    input  logic                        stall_id,
    input  logic                        in_valid,
    input  logic [31:0]                 in_pc,
    input  logic [ADDR_W-1:0]           in_rs,
    input  logic [ADDR_W-1:0]           in_rt,
    input  logic                        in_rs_use,
    input  logic                        in_rt_use,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic [NUM_FWD-1:0]          fwd_pend,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
    input  logic                        wb_we,
    input  logic [ADDR_W-1:0]           wb_waddr,
    input  logic [DATA_W-1:0]           wb_wdata,
    output logic                        id_valid,
    output logic [31:0]                 id_pc,
    output logic [ADDR_W-1:0]           rs_addr,
    output logic [ADDR_W-1:0]           rt_addr,
    output logic [DATA_W-1:0]           rdata1,
    output logic [DATA_W-1:0]           rdata2,
    output logic                        stallreq,
    output logic [CNT_W-1:0]            hazard_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic               valid_q, valid_d;
    logic [31:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]  rs_q, rs_d;
    logic [ADDR_W-1:0]  rt_q, rt_d;
    logic               rs_use_q, rs_use_d;
    logic               rt_use_q, rt_use_d;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  regs_d [NREG];
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  opnd [2];
    logic [1:0]         haz;

    // Pipeline register next state: bubble beats load beats hold.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rs_use_d = rs_use_q;
        rt_use_d = rt_use_q;
        if (stall_if && !stall_id) begin
            valid_d  = 1'b0;
            pc_d     = '0;
            rs_d     = '0;
            rt_d     = '0;
            rs_use_d = 1'b0;
            rt_use_d = 1'b0;
        end else if (!stall_if) begin
            valid_d  = in_valid;
            pc_d     = in_pc;
            rs_d     = in_rs;
            rt_d     = in_rt;
            rs_use_d = in_rs_use;
            rt_use_d = in_rt_use;
        end
    end

    // Register file write; R0 is never written so it stays zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_waddr != '0)) begin
            regs_d[wb_waddr] = wb_wdata;
        end
    end

    // Per-port operand resolution: youngest matching forward source wins,
    // then WB write-through, then the array. Address 0 short-circuits to zero
    // so a forward aimed at R0 can neither supply data nor raise a hazard.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ADDR_W-1:0] a;
        logic              u;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign a = (p == 0) ? rs_q : rt_q;
        assign u = (p == 0) ? rs_use_q : rt_use_q;

        // Scan oldest to youngest so the youngest match is the last one written.
        always_comb begin
            data = regs_q[a];
            pend = 1'b0;
            if (wb_we && (wb_waddr == a)) begin
                data = wb_wdata;
            end
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_we[i] && (fwd_waddr[i*ADDR_W +: ADDR_W] == a)) begin
                    data = fwd_wdata[i*DATA_W +: DATA_W];
                    pend = fwd_pend[i];
                end
            end
            if (a == '0) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign opnd[p] = data;
        assign haz[p]  = valid_q & u & pend;
    end

    assign stallreq = |haz;

    // Saturating count of cycles spent requesting a load-use stall.
    always_comb begin
        cnt_d = cnt_q;
        if (stallreq && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // All state clears asynchronously, including the register array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rs_use_q <= 1'b0;
            rt_use_q <= 1'b0;
            regs_q   <= '{default: '0};
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rs_use_q <= rs_use_d;
            rt_use_q <= rt_use_d;
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
        end
    end

    assign id_valid   = valid_q & ~stallreq;
    assign id_pc      = pc_q;
    assign rs_addr    = rs_q;
    assign rt_addr    = rt_q;
    assign rdata1     = opnd[0];
    assign rdata2     = opnd[1];
    assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_id_operand_unit.sv
module tb_id_operand_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_FWD = 3;
    localparam int CNT_W   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       stall_if, stall_id;
    logic                       in_valid;
    logic [31:0]                in_pc;
    logic [ADDR_W-1:0]          in_rs, in_rt;
    logic                       in_rs_use, in_rt_use;
    logic [NUM_FWD-1:0]         fwd_we, fwd_pend;
    logic [NUM_FWD*ADDR_W-1:0]  fwd_waddr;
    logic [NUM_FWD*DATA_W-1:0]  fwd_wdata;
    logic                       wb_we;
    logic [ADDR_W-1:0]          wb_waddr;
    logic [DATA_W-1:0]          wb_wdata;
    logic                       id_valid;
    logic [31:0]                id_pc;
    logic [ADDR_W-1:0]          rs_addr, rt_addr;
    logic [DATA_W-1:0]          rdata1, rdata2;
    logic                       stallreq;
    logic [CNT_W-1:0]           hazard_cnt;

    id_operand_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .in_valid(in_valid), .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt),
        .in_rs_use(in_rs_use), .in_rt_use(in_rt_use),
        .fwd_we(fwd_we), .fwd_pend(fwd_pend), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .id_valid(id_valid), .id_pc(id_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rdata1(rdata1), .rdata2(rdata2), .stallreq(stallreq), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    localparam int S_VALID = 0, S_PC = 1, S_RS = 2, S_RT = 3,
                   S_RD1 = 4, S_RD2 = 5, S_STALL = 6, S_CNT = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void push(input string tag, input int sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endfunction

    function automatic logic [31:0] obs_of(input int sel);
        case (sel)
            S_VALID: return 32'(id_valid);
            S_PC:    return id_pc;
            S_RS:    return 32'(rs_addr);
            S_RT:    return 32'(rt_addr);
            S_RD1:   return rdata1;
            S_RD2:   return rdata2;
            S_STALL: return 32'(stallreq);
            default: return 32'(hazard_cnt);
        endcase
    endfunction

    // Let combinational outputs settle, then compare everything queued.
    task automatic check_now();
        exp_t        e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs_of(e.sel);
            total++;
            assert (o === e.exp) passed++;
            else $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc,
                             input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                             input logic rsu, input logic rtu);
        in_valid  = v;
        in_pc     = pc;
        in_rs     = rs;
        in_rt     = rt;
        in_rs_use = rsu;
        in_rt_use = rtu;
    endtask

    task automatic set_fwd(input int i, input logic we, input logic pend,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        fwd_we[i]                    = we;
        fwd_pend[i]                  = pend;
        fwd_waddr[i*ADDR_W +: ADDR_W] = a;
        fwd_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        rst = 1'b0;
        stall_if = 1'b0; stall_id = 1'b0;
        set_instr(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
        fwd_we = '0; fwd_pend = '0; fwd_waddr = '0; fwd_wdata = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;

        // Power-on reset values
        push("rst_valid", S_VALID, 0); push("rst_pc", S_PC, 0);
        push("rst_rs", S_RS, 0);       push("rst_rt", S_RT, 0);
        push("rst_rd1", S_RD1, 0);     push("rst_rd2", S_RD2, 0);
        push("rst_stall", S_STALL, 0); push("rst_cnt", S_CNT, 0);
        check_now();
        @(negedge clk);
        rst = 1'b1;

        // Write R5 and capture an instruction reading it
        wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
        set_instr(1'b1, 32'h100, 5'd5, 5'd0, 1'b1, 1'b0);
        tick();
        wb_we = 1'b0;
        push("cap_valid", S_VALID, 1); push("cap_pc", S_PC, 32'h100);
        push("cap_rs", S_RS, 5); push("r5_read", S_RD1, 32'h1234);
        check_now();

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        push("arst_valid", S_VALID, 0); push("arst_pc", S_PC, 0);
        push("arst_rs", S_RS, 0); push("arst_rd1", S_RD1, 0);
        check_now();
        @(negedge clk);
        rst = 1'b1;
        tick();
        push("post_rst_rs", S_RS, 5); push("post_rst_r5", S_RD1, 0);
        check_now();

        // Forward priority: fwd0 > fwd2 > WB write-through > array
        set_instr(1'b1, 32'h104, 5'd7, 5'd0, 1'b1, 1'b0);
        tick();
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'hAAAA0000);
        set_fwd(2, 1'b1, 1'b0, 5'd7, 32'h5555);
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h1;
        push("fwd0_wins", S_RD1, 32'hAAAA0000); push("fwd_nostall", S_STALL, 0);
        check_now();
        fwd_we[0] = 1'b0;
        push("fwd2_wins", S_RD1, 32'h5555);
        check_now();
        fwd_we[2] = 1'b0;
        push("wb_through", S_RD1, 32'h1);
        check_now();
        tick();
        wb_we = 1'b0;
        push("r7_array", S_RD1, 32'h1);
        check_now();

        // Load-use hazard on rt
        set_instr(1'b1, 32'h200, 5'd0, 5'd9, 1'b0, 1'b1);
        tick();
        set_fwd(0, 1'b1, 1'b1, 5'd9, 32'h0);
        push("lu_stall", S_STALL, 1); push("lu_valid", S_VALID, 0);
        push("lu_cnt0", S_CNT, 0);
        check_now();
        stall_if = 1'b1; stall_id = 1'b1;
        tick();
        push("lu_cnt1", S_CNT, 1); push("lu_hold_pc", S_PC, 32'h200);
        push("lu_stall_hold", S_STALL, 1);
        check_now();
        tick();
        push("lu_cnt2", S_CNT, 2);
        check_now();
        set_fwd(0, 1'b1, 1'b0, 5'd9, 32'hBEEF);
        push("lu_clear", S_STALL, 0); push("lu_valid1", S_VALID, 1);
        push("lu_rd2", S_RD2, 32'hBEEF);
        check_now();
        tick();
        push("lu_cnt_stop", S_CNT, 2);
        check_now();

        // Hazard masking: use bit clear
        stall_if = 1'b0; stall_id = 1'b0;
        set_instr(1'b1, 32'h300, 5'd0, 5'd9, 1'b0, 1'b0);
        tick();
        fwd_pend[0] = 1'b1;
        push("nouse_stall", S_STALL, 0); push("nouse_valid", S_VALID, 1);
        push("nouse_rd2", S_RD2, 32'hBEEF);
        check_now();

        // Hazard masking: address 0
        set_instr(1'b1, 32'h304, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        push("a0_stall", S_STALL, 0); push("a0_rd1", S_RD1, 0);
        push("a0_valid", S_VALID, 1);
        check_now();

        // Hazard masking: younger non-pending match shadows pending older one
        set_instr(1'b1, 32'h308, 5'd0, 5'd9, 1'b0, 1'b1);
        tick();
        set_fwd(0, 1'b1, 1'b0, 5'd9, 32'h1111);
        set_fwd(1, 1'b1, 1'b1, 5'd9, 32'h2222);
        push("shadow_stall", S_STALL, 0); push("shadow_rd2", S_RD2, 32'h1111);
        check_now();
        fwd_we[0] = 1'b0;
        push("unshadow_stall", S_STALL, 1); push("unshadow_rd2", S_RD2, 32'h2222);
        check_now();
        fwd_we[0] = 1'b1;
        push("reshadow_stall", S_STALL, 0); push("mask_cnt", S_CNT, 2);
        check_now();

        // Stall bus: bubble, load, hold, release
        fwd_we = '0; fwd_pend = '0;
        stall_if = 1'b1; stall_id = 1'b0;
        set_instr(1'b1, 32'h400, 5'd3, 5'd4, 1'b0, 1'b0);
        tick();
        push("bub_valid", S_VALID, 0); push("bub_pc", S_PC, 0); push("bub_rs", S_RS, 0);
        check_now();
        stall_if = 1'b0;
        set_instr(1'b1, 32'h500, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        push("load_pc", S_PC, 32'h500);
        check_now();
        stall_if = 1'b1; stall_id = 1'b1;
        set_instr(1'b1, 32'h600, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            push($sformatf("hold_pc_%0d", k), S_PC, 32'h500);
            check_now();
        end
        stall_if = 1'b0; stall_id = 1'b0;
        tick();
        push("release_pc", S_PC, 32'h600);
        check_now();

        // Bubble loaded while stallreq is high
        set_instr(1'b1, 32'h700, 5'd0, 5'd9, 1'b0, 1'b1);
        set_fwd(0, 1'b1, 1'b1, 5'd9, 32'h0);
        tick();
        push("bubhaz_stall", S_STALL, 1);
        check_now();
        stall_if = 1'b1; stall_id = 1'b0;
        tick();
        push("bubhaz_drop", S_STALL, 0); push("bubhaz_valid", S_VALID, 0);
        push("bubhaz_cnt", S_CNT, 3);
        check_now();

        // Counter saturation over 20 hazard cycles
        stall_if = 1'b0;
        tick();
        stall_if = 1'b1; stall_id = 1'b1;
        repeat (5) tick();
        push("sat_cnt_mid", S_CNT, 8);
        check_now();
        repeat (15) tick();
        push("sat_cnt", S_CNT, 15); push("sat_stall", S_STALL, 1);
        check_now();
        tick();
        push("sat_hold", S_CNT, 15);
        check_now();

        // Reset clears the counter asynchronously
        #2 rst = 1'b0;
        push("final_rst_cnt", S_CNT, 0); push("final_rst_stall", S_STALL, 0);
        check_now();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_operand_unit.md
# id_operand_unit

Parametrised decode-stage operand unit for the five-stage pipeline; the successor to the fixed 32×32, three-source-forwarding decode read path. It holds the IF→ID pipeline register and the register file (N registers, R0 hard-wired to zero). It resolves both source operands through a configurable number of priority-ordered forwarding sources. It raises a stall request on load-use hazards, which the current decode stage cannot detect. It sits between IF and the decoder/EX bus builder. The decoder consumes `rs_addr`/`rt_addr` plus the resolved operands.

## Interface
Parameters:
- `DATA_W`, 32, operand/register width
- `ADDR_W`, 5, register address width; register count = 2^ADDR_W
- `NUM_FWD`, 3, number of forwarding sources; index 0 = youngest (EX), ascending = older
- `CNT_W`, 16, width of hazard-stall statistics counter

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall_if`  in  1  stall bit of IF stage (1 = Stop)
- `stall_id`  in  1  stall bit of ID stage (1 = Stop)
- `in_valid`  in  1  IF presents a valid instruction
- `in_pc`  in  32  PC of IF instruction
- `in_rs`, `in_rt`  in  ADDR_W each  source register addresses of IF instruction
- `in_rs_use`, `in_rt_use`  in  1 each  instruction actually reads that source
- `fwd_we`  in  NUM_FWD  per-source write enable
- `fwd_pend`  in  NUM_FWD  per-source result not yet available (load in flight)
- `fwd_waddr`  in  NUM_FWD*ADDR_W  source i at `[i*ADDR_W +: ADDR_W]`
- `fwd_wdata`  in  NUM_FWD*DATA_W  source i at `[i*DATA_W +: DATA_W]`
- `wb_we`, `wb_waddr`, `wb_wdata`  in  1/ADDR_W/DATA_W  register-file write port
- `id_valid`  out  1  registered instruction valid and not hazarded
- `id_pc`  out  32  registered PC
- `rs_addr`, `rt_addr`  out  ADDR_W  registered source addresses
- `rdata1`, `rdata2`  out  DATA_W  resolved operands
- `stallreq`  out  1  load-use hazard, request ID stall
- `hazard_cnt`  out  CNT_W  saturating count of cycles with `stallreq`=1

## Operation
- Pipeline register, in priority order:
  - `rst`=0: all fields 0.
  - `stall_if`=1 and `stall_id`=0: load bubble (valid=0, pc/addr/use=0).
  - `stall_if`=0: load `in_*`.
  - Otherwise: hold.
- Register file: 2^ADDR_W × DATA_W.
  - Write on `wb_we` & `wb_waddr`≠0 at the rising edge.
  - Cleared to 0 on reset.
  - R0 always reads 0.
- Operand resolution for each port, with address a = `rs_addr` or `rt_addr`:
  - If a = 0, the result is 0. Forwarding is never applied to address 0.
  - Otherwise, scan sources i = 0…NUM_FWD-1 in order. The first i with `fwd_we[i]` & `fwd_waddr_i`=a wins.
  - If no source matches and `wb_we` & `wb_waddr`=a, the result is `wb_wdata` (write-through).
  - Otherwise, the result is the array value.
- Hazard: a port is hazarded when all of the following hold:
  - valid=1
  - its use bit is 1
  - a≠0
  - the winning source has `fwd_pend`=1
- A pending source that is shadowed by a younger matching source does not hazard.
- `stallreq` = port1 hazard | port2 hazard. It is purely combinational from registered state and the forwarding inputs.
- `id_valid` = valid & ~`stallreq`.
- `hazard_cnt` increments each cycle `stallreq`=1 and saturates at 2^CNT_W−1. It clears only on reset.

## Timing
- Reset values: `id_valid`=0, `id_pc`=0, `rs_addr`=`rt_addr`=0, `rdata1`=`rdata2`=0, `stallreq`=0, `hazard_cnt`=0.
- Reset asserts asynchronously mid-operation. All state clears immediately. The first capture happens on the first rising edge after `rst` returns to 1.
- Instruction captured at edge N → `id_*` valid during cycle N+1. Operands reflect forwarding inputs in that same cycle, with zero added latency.
- WB write at edge N and read of the same address in cycle N: the read returns `wb_wdata` via write-through. The array holds the value from edge N.
- When the external stall controller answers `stallreq` with `stall_if`=`stall_id`=1, the register holds and operands re-resolve each cycle. `stallreq` drops in the cycle the pending source clears or moves to a non-pending index.
- Simultaneous `stall_if`=1, `stall_id`=0 and `stallreq`=1: the bubble is loaded; `stallreq` drops the next cycle.

## Test plan
- **Reset:** `rst`=0 mid-run with R5=0x1234 → all outputs 0 combinationally. After release, a read of R5 returns 0.
- **Forward priority:** rs=7; fwd0 (7, 0xAAAA0000), fwd2 (7, 0x5555), WB (7, 0x1) → `rdata1`=0xAAAA0000. Deassert fwd0 → `rdata1`=0x5555. Deassert fwd2 → `rdata1`=0x1.
- **Load-use:** rt=9, `in_rt_use`=1, fwd0 we=1, pend=1, addr=9 → `stallreq`=1, `id_valid`=0, `hazard_cnt` increments per cycle. Clear pend with wdata=0xBEEF → `stallreq`=0, `rdata2`=0xBEEF.
- **Hazard masking:**
  - rt_use=0 → `stallreq`=0.
  - Address 0 with fwd0 pend on addr 0 → `stallreq`=0, `rdata1`=0.
  - Younger non-pending fwd0 on 9 shadowing pending fwd1 on 9 → `stallreq`=0.
- **Stall bus:**
  - `stall_if`=1, `stall_id`=0 → next cycle `id_valid`=0, `id_pc`=0.
  - Both stalls=1 → `id_pc` held for 3 cycles.
  - Both=0 → new PC captured.
- **Counter saturation:** CNT_W=4 with 20 hazard cycles → `hazard_cnt`=15.
